aes_key_sched_ctrl: RTL

Iterative AES-128 key-schedule controller that sequences a single shared `SubWord` instance to produce round keys 0 through 10 from a 128-bit cipher key. Each round key is presented on a valid/ready handshake to the cipher round datapath. Generation is one round at a time, so a slow consumer stalls the schedule and nothing is buffered.

---
 rtl/aes_key_sched_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller.
// Produces round keys 0..NR one at a time from a 128-bit cipher key using a
// single shared SubWord block. Each round key is offered on a valid/ready
// handshake; a stalled consumer stalls the schedule, and nothing is buffered.

// Four parallel AES S-boxes forming one SubWord. The S-box is computed as the
// GF(2^8) multiplicative inverse followed by the AES affine transform, so no
// lookup table has to be maintained by hand.
module aes_subword (
  input  logic [7:0] s0_in,
  input  logic [7:0] s1_in,
  input  logic [7:0] s2_in,
  input  logic [7:0] s3_in,
  output logic [7:0] d0_out,
  output logic [7:0] d1_out,
  output logic [7:0] d2_out,
  output logic [7:0] d3_out
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      if (aa[7]) begin
        aa = {aa[6:0], 1'b0} ^ 8'h1b;
      end else begin
        aa = {aa[6:0], 1'b0};
      end
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // AES S-box: inverse as a^254 (maps 0 to 0), then the affine transform
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  // Byte-wise substitution, lane order preserved
  always_comb begin
    d0_out = aes_sbox(s0_in);
    d1_out = aes_sbox(s1_in);
    d2_out = aes_sbox(s2_in);
    d3_out = aes_sbox(s3_in);
  end

endmodule

// Protocol properties of the key-schedule handshake, kept apart from the logic.
module aes_key_sched_ctrl_chk (
  input logic         clk,
  input logic         rst_n,
  input logic         rk_ready,
  input logic         rk_valid,
  input logic [127:0] round_key,
  input logic [3:0]   round_idx,
  input logic         busy,
  input logic         done
);

  // done and rk_valid are mutually exclusive
  a_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && rk_valid));

  // A stalled round key stays offered and unchanged
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rk_valid && !rk_ready) |=> (rk_valid && $stable(round_key) && $stable(round_idx)));

  // The completion pulse lands in an idle cycle
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);

endmodule

module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SUB  = 2'd2,
    ST_XOR  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t         state_r;
  logic [127:0]   round_key_r;
  logic [3:0]     round_idx_r;
  logic [31:0]    temp_r;
  logic           rk_valid_r;
  logic           busy_r;
  logic           done_r;

  logic [31:0]    rot_word_s;
  logic [31:0]    sub_word_s;
  logic [7:0]     sub_d0_s;
  logic [7:0]     sub_d1_s;
  logic [7:0]     sub_d2_s;
  logic [7:0]     sub_d3_s;
  logic [3:0]     next_idx_s;
  logic [7:0]     rcon_s;
  logic [31:0]    t_s;
  logic [31:0]    w0_new_s;
  logic [31:0]    w1_new_s;
  logic [31:0]    w2_new_s;
  logic [31:0]    w3_new_s;
  logic [127:0]   next_key_s;

  // Round constant for the round being generated (1..10); exact 8-bit values
  function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // RotWord of w3; the MSB byte feeds lane 0 of the shared SubWord
  always_comb begin
    rot_word_s = {round_key_r[23:0], round_key_r[31:24]};
    sub_word_s = {sub_d0_s, sub_d1_s, sub_d2_s, sub_d3_s};
  end

  aes_subword u_subword (
    .s0_in  (rot_word_s[31:24]),
    .s1_in  (rot_word_s[23:16]),
    .s2_in  (rot_word_s[15:8]),
    .s3_in  (rot_word_s[7:0]),
    .d0_out (sub_d0_s),
    .d1_out (sub_d1_s),
    .d2_out (sub_d2_s),
    .d3_out (sub_d3_s)
  );

  // XOR chain building the next round key from the registered SubWord result
  always_comb begin
    next_idx_s = round_idx_r + 4'd1;
    rcon_s     = rcon_lookup(next_idx_s);
    t_s        = temp_r ^ {rcon_s, 24'h000000};
    w0_new_s   = round_key_r[127:96] ^ t_s;
    w1_new_s   = round_key_r[95:64]  ^ w0_new_s;
    w2_new_s   = round_key_r[63:32]  ^ w1_new_s;
    w3_new_s   = round_key_r[31:0]   ^ w2_new_s;
    next_key_s = {w0_new_s, w1_new_s, w2_new_s, w3_new_s};
  end

  // Schedule sequencer: capture key, offer each round key, then SubWord and XOR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      round_key_r <= 128'h0;
      round_idx_r <= 4'd0;
      temp_r      <= 32'h0;
      rk_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            round_key_r <= key_in;
            round_idx_r <= 4'd0;
            rk_valid_r  <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_EMIT;
          end else begin
            rk_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          done_r <= 1'b0;
          if (rk_ready) begin
            rk_valid_r <= 1'b0;
            if (round_idx_r == LAST_IDX) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= ST_SUB;
            end
          end else begin
            rk_valid_r <= 1'b1;
            state_r    <= ST_EMIT;
          end
        end
        ST_SUB: begin
          temp_r  <= sub_word_s;
          done_r  <= 1'b0;
          state_r <= ST_XOR;
        end
        ST_XOR: begin
          round_key_r <= next_key_s;
          round_idx_r <= next_idx_s;
          rk_valid_r  <= 1'b1;
          done_r      <= 1'b0;
          state_r     <= ST_EMIT;
        end
        default: begin
          rk_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign rk_valid  = rk_valid_r;
  assign round_key = round_key_r;
  assign round_idx = round_idx_r;
  assign busy      = busy_r;
  assign done      = done_r;

  aes_key_sched_ctrl_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid_r),
    .round_key (round_key_r),
    .round_idx (round_idx_r),
    .busy      (busy_r),
    .done      (done_r)
  );

endmodule
